apu_dmc: RTL and testbench
==========================

Name: apu_dmc

Overview:
- APU delta-modulation channel: the consumer end of the DMC DMA handshake.
- Decodes CPU writes to $4010-$4013/$4015 and requests sample bytes (dmc_req / dmc_init / dmc_addr_wr toward the DMA engine).
- Accepts bytes on dmc_read into a 1-byte sample buffer and shifts them out as 1-bit deltas on a 7-bit output level.
- Raises the DMC IRQ at sample end and sits beside the DMA engine in the APU.

Parameters:
PAL, 0, 0 selects NTSC rate table, 1 selects PAL rate table (periods in CPU cycles)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cpu_ce  in  1  one-clk pulse per CPU cycle; all timing below counts cpu_ce
rw_i  in  1  CPU read(1)/write(0)
cpu_addr_i  in  16  CPU address
cpu_data_i  in  8  CPU write data
dmc_read  in  1  DMA delivers sample byte this clk
dmc_data_i  in  8  sample byte, valid with dmc_read
dmc_req  out  1  one-clk request pulse for next sample byte
dmc_init  out  1  one-clk pulse: DMA reloads sample address from its $4012 copy
dmc_addr_wr  out  1  combinational: write to $4012 this clk and cpu_ce
sample  out  7  DMC output level
dmc_active  out  1  bytes_remaining != 0 ($4015 bit 4)
irq  out  1  DMC interrupt flag ($4015 bit 7)

Behaviour:
- Register write = cpu_ce && !rw_i && address match; all state updates occur on such clk edges.
- $4010:
  - irq_en = d[7], loop = d[6], rate = d[3:0].
  - d[7]=0 clears irq.
- $4011: level = d[6:0]. Overrides a same-cycle delta update.
- $4012: asserts dmc_addr_wr only; no local state.
- $4013: length = d. Sample byte count = {d,4'b0001} (12 bit, 1..4081).
- $4015:
  - Clears irq.
  - d[4]=0: bytes_remaining = 0. An in-flight DMA byte is still accepted into the buffer.
  - d[4]=1 with bytes_remaining==0: bytes_remaining = length count and pulse dmc_init next clk.
  - d[4]=1 with bytes_remaining!=0: no effect.
- Rate table, NTSC (CPU cycles), indexed by rate 0..15: 428,380,340,320,286,254,226,214,190,160,142,128,106,84,72,54.
- Rate table, PAL: 398,354,316,298,276,236,210,198,176,148,132,118,98,78,66,50.
- Timer:
  - 9-bit down counter, decremented on cpu_ce.
  - At 0 it reloads period-1 and produces one output clock.
  - A rate write takes effect at the next reload.
- Output clock, delta step when !silence:
  - If shift[0]=1 and level<=125: level += 2.
  - If shift[0]=0 and level>=2: level -= 2.
  - Otherwise level is unchanged (saturation, no wrap).
- Output clock, shift step (always): shift >>= 1 and bits_left -= 1.
- Output clock, cycle end (bits_left reaches 0 after the shift step):
  - bits_left = 8.
  - If buffer full: shift = buffer, buffer empty, silence = 0.
  - Else silence = 1.
- Request FSM:
  - States IDLE -> WAIT.
  - IDLE: if buffer empty && bytes_remaining!=0 && !dmc_init pending, pulse dmc_req for exactly 1 clk and go to WAIT.
  - WAIT: hold (no further req) until dmc_read, then go to IDLE.
- On dmc_read: buffer = dmc_data_i, buffer full, and bytes_remaining -= 1 (if nonzero). If the result is 0:
  - loop=1: reload count and pulse dmc_init. dmc_init always precedes the resulting dmc_req by at least 1 clk.
  - loop=0 and irq_en=1: set irq.
- dmc_read while IDLE is ignored, apart from loading the buffer if it is empty.
- Reset (async, rst_n low), all to 0 except as noted:
  - level, bytes_remaining, irq, irq_en, loop, rate, length, buffer valid.
  - silence=1, bits_left=8, timer=period(0)-1.
  - FSM IDLE.
  - Outputs: dmc_req=0, dmc_init=0, sample=0, dmc_active=0, irq=0.
- Reset mid-request abandons WAIT. A later dmc_read is treated as unsolicited.

Test Plan:
- Reset release, $4013=0, $4012=$C0, $4015=$10 -> dmc_addr_wr on the $4012 write; dmc_init 1 clk later; dmc_req once; after dmc_read, dmc_active=0 (1 byte).
- $4011=$40, $4010=$0F, byte $FF delivered -> sample rises 64,66,... by 2 every 54 cpu_ce, 8 steps to 80.
- $4011=$7E, byte $FF -> first step saturates at 126 (>125), then holds. $4011=$01, byte $00 -> level stays 1.
- $4010=$80, $4013=$01 (17 bytes), no loop -> exactly 17 dmc_req pulses; irq=1 after the 17th dmc_read; $4015 write clears irq.
- $4010=$40 (loop), $4013=$00 -> dmc_init pulse after every dmc_read; dmc_active stays 1; irq never set.
- Buffer starved (dmc_read withheld 20 output clocks) -> silence, level constant. $4015=$00 while in WAIT -> late dmc_read is absorbed and no further dmc_req. Assert rst_n low mid-WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/apu_dmc.sv
// apu_dmc: APU delta-modulation channel. Decodes $4010-$4015 writes, requests sample
// bytes from the DMA engine and plays them as 1-bit deltas on a 7-bit output level.
module apu_dmc #(
   parameter bit PAL = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_ce,
   input  logic        rw_i,
   input  logic [15:0] cpu_addr_i,
   input  logic [7:0]  cpu_data_i,
   input  logic        dmc_read,
   input  logic [7:0]  dmc_data_i,
   output logic        dmc_req,
   output logic        dmc_init,
   output logic        dmc_addr_wr,
   output logic [6:0]  sample,
   output logic        dmc_active,
   output logic        irq
);
   localparam int unsigned TW = 9;
   localparam int unsigned CW = 12;
   localparam int unsigned LW = 7;
   localparam int unsigned BW = 8;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t        state, state_n;
   logic          req_n, init_n;
   logic          wr, wr_4010, wr_4011, wr_4013, wr_4015;
   logic          irq_en, loop;
   logic [3:0]    rate;
   logic [BW-1:0] length;
   logic [CW-1:0] bytes_rem, bytes_rem_n, len_count;
   logic          buf_full, silence, out_clk, accept, last_byte;
   logic [BW-1:0] buf_data, shift;
   logic [3:0]    bits_left;
   logic [TW-1:0] timer;

   // Timer reload value (period - 1) for a rate index
   function automatic logic [TW-1:0] period_m1(input logic [3:0] r);
      int unsigned p;
      p = 428;
      case (r)
         4'd0:  p = PAL ? 398 : 428;
         4'd1:  p = PAL ? 354 : 380;
         4'd2:  p = PAL ? 316 : 340;
         4'd3:  p = PAL ? 298 : 320;
         4'd4:  p = PAL ? 276 : 286;
         4'd5:  p = PAL ? 236 : 254;
         4'd6:  p = PAL ? 210 : 226;
         4'd7:  p = PAL ? 198 : 214;
         4'd8:  p = PAL ? 176 : 190;
         4'd9:  p = PAL ? 148 : 160;
         4'd10: p = PAL ? 132 : 142;
         4'd11: p = PAL ? 118 : 128;
         4'd12: p = PAL ? 98  : 106;
         4'd13: p = PAL ? 78  : 84;
         4'd14: p = PAL ? 66  : 72;
         default: p = PAL ? 50 : 54;
      endcase
      return TW'(p - 1);
   endfunction

   // Register decode and per-clk event qualifiers
   always_comb begin
      wr          = cpu_ce && !rw_i;
      wr_4010     = wr && (cpu_addr_i == 16'h4010);
      wr_4011     = wr && (cpu_addr_i == 16'h4011);
      wr_4013     = wr && (cpu_addr_i == 16'h4013);
      wr_4015     = wr && (cpu_addr_i == 16'h4015);
      dmc_addr_wr = wr && (cpu_addr_i == 16'h4012);
      len_count   = {length, 4'b0001};
      out_clk     = cpu_ce && (timer == '0);
      accept      = dmc_read && (state == S_WAIT);
      last_byte   = accept && (bytes_rem == CW'(1));
   end

   // Byte counter and DMA address reload; a $4015 write overrides a same-clk fetch
   always_comb begin
      bytes_rem_n = bytes_rem;
      init_n      = 1'b0;
      if (accept && (bytes_rem != '0))
         bytes_rem_n = bytes_rem - CW'(1);
      if (last_byte && loop) begin
         bytes_rem_n = len_count;
         init_n      = 1'b1;
      end
      if (wr_4015) begin
         if (!cpu_data_i[4]) begin
            bytes_rem_n = '0;
            init_n      = 1'b0;
         end else if (bytes_rem == '0) begin
            bytes_rem_n = len_count;
            init_n      = 1'b1;
         end
      end
   end

   // Request FSM: a pending dmc_init holds off the request so the DMA reloads first
   always_comb begin
      state_n = state;
      req_n   = 1'b0;
      case (state)
         S_IDLE:
            if (!buf_full && (bytes_rem != '0) && !dmc_init) begin
               state_n = S_WAIT;
               req_n   = 1'b1;
            end
         S_WAIT:
            if (dmc_read)
               state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         dmc_req    <= 1'b0;
         dmc_init   <= 1'b0;
         bytes_rem  <= '0;
         dmc_active <= 1'b0;
         timer      <= period_m1(4'd0);
         irq_en     <= 1'b0;
         loop       <= 1'b0;
         rate       <= 4'd0;
         length     <= '0;
         irq        <= 1'b0;
         sample     <= '0;
         buf_full   <= 1'b0;
         buf_data   <= '0;
         shift      <= '0;
         bits_left  <= 4'd8;
         silence    <= 1'b1;
      end else begin
         state      <= state_n;
         dmc_req    <= req_n;
         dmc_init   <= init_n;
         bytes_rem  <= bytes_rem_n;
         dmc_active <= (bytes_rem_n != '0);

         if (cpu_ce)
            timer <= (timer == '0) ? period_m1(rate) : timer - TW'(1);

         // Output unit: delta, shift, and buffer hand-off at the end of each 8-bit cycle
         if (out_clk) begin
            if (!silence) begin
               if (shift[0] && (sample <= LW'(125)))
                  sample <= sample + LW'(2);
               else if (!shift[0] && (sample >= LW'(2)))
                  sample <= sample - LW'(2);
            end
            shift <= {1'b0, shift[BW-1:1]};
            if (bits_left == 4'd1) begin
               bits_left <= 4'd8;
               if (buf_full) begin
                  shift    <= buf_data;
                  buf_full <= 1'b0;
                  silence  <= 1'b0;
               end else begin
                  silence  <= 1'b1;
               end
            end else begin
               bits_left <= bits_left - 4'd1;
            end
         end

         // Placed after the output unit so a byte landing on a cycle end is kept
         if (dmc_read && ((state == S_WAIT) || !buf_full)) begin
            buf_data <= dmc_data_i;
            buf_full <= 1'b1;
         end

         if (last_byte && !loop && irq_en)
            irq <= 1'b1;

         if (wr_4010) begin
            irq_en <= cpu_data_i[7];
            loop   <= cpu_data_i[6];
            rate   <= cpu_data_i[3:0];
            if (!cpu_data_i[7])
               irq <= 1'b0;
         end
         if (wr_4011)
            sample <= cpu_data_i[6:0];
         if (wr_4013)
            length <= cpu_data_i;
         if (wr_4015)
            irq <= 1'b0;
      end
   end
endmodule

// File: tb/tb_apu_dmc.sv
// tb_apu_dmc: directed stimulus with a DMA responder model; a scoreboard monitor checks
// every change of the output level against an expected-level queue.
module tb_apu_dmc;
   logic        clk, rst_n, cpu_ce, rw_i, dmc_read;
   logic [15:0] cpu_addr_i;
   logic [7:0]  cpu_data_i, dmc_data_i;
   logic        dmc_req, dmc_init, dmc_addr_wr, dmc_active, irq;
   logic [6:0]  sample;

   typedef struct {
      logic [6:0] lvl;
      int         gap;
   } exp_t;

   exp_t       exp_q[$];
   int         checks = 0;
   int         failures = 0;
   int         req_count = 0;
   int         read_count = 0;
   int         init_count = 0;
   logic       dma_hold = 1'b0;
   logic [7:0] dma_byte = 8'h00;
   logic       pending = 1'b0;

   apu_dmc #(.PAL(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .cpu_ce(cpu_ce), .rw_i(rw_i),
      .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
      .dmc_read(dmc_read), .dmc_data_i(dmc_data_i),
      .dmc_req(dmc_req), .dmc_init(dmc_init), .dmc_addr_wr(dmc_addr_wr),
      .sample(sample), .dmc_active(dmc_active), .irq(irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic push(input logic [6:0] l, input int g);
      exp_t e;
      e.lvl = l;
      e.gap = g;
      exp_q.push_back(e);
   endtask

   // n levels starting at first, stepping by step, spaced gap clks after the first
   task automatic push_ramp(input int first, input int step, input int n, input int gap);
      for (int i = 0; i < n; i++)
         push(7'(first + step * i), (i == 0) ? 0 : gap);
   endtask

   task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      rw_i = 1'b0; cpu_addr_i = a; cpu_data_i = d;
      @(negedge clk);
      rw_i = 1'b1; cpu_addr_i = 16'h0000; cpu_data_i = 8'h00;
   endtask

   task automatic wait_reads(input int target, input int bound, input string name);
      int n;
      n = 0;
      while (read_count < target && n < bound) begin
         @(negedge clk);
         n++;
      end
      check(name, read_count, target);
   endtask

   task automatic wait_reqs(input int target, input int bound, input string name);
      int n;
      n = 0;
      while (req_count < target && n < bound) begin
         @(negedge clk);
         n++;
      end
      check(name, req_count, target);
   endtask

   task automatic wait_level(input logic [6:0] lvl, input int bound, input string name);
      int n;
      n = 0;
      while (sample !== lvl && n < bound) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(sample), 32'(lvl));
   endtask

   task automatic drain(input int cycles);
      repeat (cycles) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 0);
   endtask

   // One single-byte sample ($4013 = 0, no loop), then let it play out completely
   task automatic play_byte(input logic [7:0] b, input string name);
      int r0;
      dma_byte = b;
      r0 = read_count;
      cpu_wr(16'h4015, 8'h10);
      wait_reads(r0 + 1, 800, name);
      drain(1500);
   endtask

   // DMA engine model: answers each request with dma_byte unless held off
   initial begin : dma_model
      dmc_read = 1'b0;
      dmc_data_i = 8'h00;
      forever begin
         @(negedge clk);
         dmc_read = 1'b0;
         if (dmc_init)
            init_count++;
         if (dmc_req) begin
            req_count++;
            check("req_not_with_init", 32'(dmc_init), 32'd0);
            pending = 1'b1;
         end
         if (pending && !dma_hold && rst_n) begin
            dmc_data_i = dma_byte;
            dmc_read   = 1'b1;
            pending    = 1'b0;
            read_count++;
         end
      end
   end

   // Scoreboard: every change of the output level must match the next expected entry
   initial begin : sb_monitor
      logic [6:0] prev;
      int         ncyc, last_chg;
      exp_t       e;
      prev = 7'd0;
      ncyc = 0;
      last_chg = 0;
      forever begin
         @(negedge clk);
         ncyc++;
         if (sample !== prev) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sample_unexpected got=%0d exp=none", sample);
            end else begin
               e = exp_q.pop_front();
               check("sample_level", 32'(sample), 32'(e.lvl));
               if (e.gap != 0)
                  check("sample_gap", ncyc - last_chg, e.gap);
            end
            prev = sample;
            last_chg = ncyc;
         end
      end
   end

   initial begin : watchdog
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int r0, q0, i0;
      rst_n = 1'b0; cpu_ce = 1'b1; rw_i = 1'b1;
      cpu_addr_i = 16'h0000; cpu_data_i = 8'h00;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_sample", 32'(sample), 32'd0);
      check("rst_req", 32'(dmc_req), 32'd0);
      check("rst_init", 32'(dmc_init), 32'd0);
      check("rst_active", 32'(dmc_active), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      rst_n = 1'b1;

      // writes without cpu_ce are ignored; reads never strobe dmc_addr_wr
      @(negedge clk);
      cpu_ce = 1'b0; rw_i = 1'b0; cpu_addr_i = 16'h4012; #1;
      check("addr_wr_no_ce", 32'(dmc_addr_wr), 32'd0);
      cpu_addr_i = 16'h4011; cpu_data_i = 8'h55;
      @(negedge clk);
      check("wr_no_ce_level", 32'(sample), 32'd0);
      cpu_ce = 1'b1; rw_i = 1'b1; cpu_addr_i = 16'h4012; #1;
      check("addr_wr_on_read", 32'(dmc_addr_wr), 32'd0);

      // test 1: one-byte sample handshake
      cpu_wr(16'h4010, 8'h0F);
      cpu_wr(16'h4013, 8'h00);
      @(negedge clk);
      rw_i = 1'b0; cpu_addr_i = 16'h4012; cpu_data_i = 8'hC0; #1;
      check("addr_wr_4012", 32'(dmc_addr_wr), 32'd1);
      @(negedge clk);
      rw_i = 1'b1; cpu_addr_i = 16'h0000; #1;
      check("addr_wr_drop", 32'(dmc_addr_wr), 32'd0);
      dma_byte = 8'h00;
      r0 = read_count; q0 = req_count; i0 = init_count;
      cpu_wr(16'h4015, 8'h10);
      check("init_after_enable", 32'(dmc_init), 32'd1);
      check("active_after_enable", 32'(dmc_active), 32'd1);
      check("no_req_with_init", 32'(dmc_req), 32'd0);
      wait_reads(r0 + 1, 20, "t1_read");
      repeat (2) @(negedge clk);
      check("t1_req_count", req_count - q0, 1);
      check("t1_init_count", init_count - i0, 1);
      check("t1_active_done", 32'(dmc_active), 32'd0);
      drain(1500);

      // test 2: $FF from 64 climbs by 2 every 54 clks to 80
      push(7'd64, 0);
      cpu_wr(16'h4011, 8'h40);
      push_ramp(66, 2, 8, 54);
      play_byte(8'hFF, "t2_read");
      check("t2_final", 32'(sample), 32'd80);

      // test 3: saturation at both ends
      push(7'd126, 0);
      cpu_wr(16'h4011, 8'h7E);
      play_byte(8'hFF, "t3a_read");
      check("sat_126_hold", 32'(sample), 32'd126);
      push(7'd1, 0);
      cpu_wr(16'h4011, 8'h01);
      play_byte(8'h00, "t3b_read");
      check("sat_1_hold", 32'(sample), 32'd1);
      push(7'd125, 0);
      cpu_wr(16'h4011, 8'h7D);
      push(7'd127, 0);
      play_byte(8'hFF, "t3c_read");
      check("sat_127_hold", 32'(sample), 32'd127);
      push(7'd2, 0);
      cpu_wr(16'h4011, 8'h02);
      push(7'd0, 0);
      play_byte(8'h00, "t3d_read");
      check("sat_0_hold", 32'(sample), 32'd0);

      // test 4: 17-byte sample with IRQ
      cpu_wr(16'h4010, 8'h8F);
      cpu_wr(16'h4013, 8'h01);
      dma_byte = 8'h00;
      r0 = read_count; q0 = req_count;
      cpu_wr(16'h4015, 8'h10);
      wait_reads(r0 + 16, 9000, "t4_reads16");
      repeat (2) @(negedge clk);
      check("irq_before_last", 32'(irq), 32'd0);
      wait_reads(r0 + 17, 1000, "t4_reads17");
      repeat (2) @(negedge clk);
      check("irq_after_last", 32'(irq), 32'd1);
      check("t4_active_done", 32'(dmc_active), 32'd0);
      repeat (1000) @(negedge clk);
      check("t4_req_count", req_count - q0, 17);
      check("irq_held", 32'(irq), 32'd1);
      cpu_wr(16'h4015, 8'h00);
      check("irq_cleared", 32'(irq), 32'd0);
      drain(500);

      // test 5: looping sample reloads after every byte
      cpu_wr(16'h4010, 8'h4F);
      cpu_wr(16'h4013, 8'h00);
      r0 = read_count; q0 = req_count; i0 = init_count;
      cpu_wr(16'h4015, 8'h10);
      wait_reads(r0 + 4, 3000, "t5_reads");
      repeat (5) @(negedge clk);
      check("loop_init_count", init_count - i0, 5);
      check("loop_req_count", req_count - q0, 4);
      check("loop_active", 32'(dmc_active), 32'd1);
      check("loop_no_irq", 32'(irq), 32'd0);
      cpu_wr(16'h4010, 8'h0F);
      cpu_wr(16'h4015, 8'h00);
      check("loop_stopped", 32'(dmc_active), 32'd0);
      drain(1500);

      // test 6: starvation, then disable while a request is outstanding
      push(7'd64, 0);
      cpu_wr(16'h4011, 8'h40);
      cpu_wr(16'h4013, 8'h01);
      push_ramp(66, 2, 8, 54);
      dma_byte = 8'hFF;
      r0 = read_count; q0 = req_count;
      cpu_wr(16'h4015, 8'h10);
      wait_reads(r0 + 1, 800, "t6_read1");
      dma_hold = 1'b1;
      wait_level(7'd80, 1500, "t6_level80");
      wait_reqs(q0 + 2, 600, "t6_req2");
      repeat (1100) @(negedge clk);
      check("starved_level", 32'(sample), 32'd80);
      check("starved_req_count", req_count - q0, 2);
      dma_byte = 8'h00;
      cpu_wr(16'h4015, 8'h00);
      check("t6_inactive", 32'(dmc_active), 32'd0);
      push_ramp(78, -2, 8, 54);
      dma_hold = 1'b0;
      wait_reads(r0 + 2, 20, "t6_late_read");
      drain(1500);
      check("t6_no_more_req", req_count - q0, 2);

      // test 7: reset while waiting; the late byte arrives unsolicited
      dma_hold = 1'b1;
      dma_byte = 8'hFF;
      q0 = req_count; r0 = read_count;
      cpu_wr(16'h4015, 8'h10);
      wait_reqs(q0 + 1, 20, "t7_req");
      repeat (3) @(negedge clk);
      push(7'd0, 0);
      rst_n = 1'b0; #1;
      check("t7_rst_sample", 32'(sample), 32'd0);
      check("t7_rst_req", 32'(dmc_req), 32'd0);
      check("t7_rst_init", 32'(dmc_init), 32'd0);
      check("t7_rst_active", 32'(dmc_active), 32'd0);
      check("t7_rst_irq", 32'(irq), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      push_ramp(2, 2, 8, 428);
      dma_hold = 1'b0;
      wait_reads(r0 + 1, 20, "t7_late_read");
      drain(7200);
      check("t7_no_req", req_count - q0, 1);
      check("t7_inactive", 32'(dmc_active), 32'd0);
      check("t7_level", 32'(sample), 32'd16);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
